class_score_engine: RTL
=======================

CLASS_SCORE_ENGINE -- requirements
Module: class_score_engine

Interface
REQ-001 SHALL have parameters: NUM_CLASSES, default 4, number of gesture classes (UP, DOWN, LEFT, RIGHT).
REQ-002 SHALL have parameters: NUM_CELLS, default 1280, voxel cells swept (5 bins x 256); COUNT_BITS, default 8, unsigned voxel count width.
REQ-003 SHALL have parameters: WEIGHT_BITS, default 8, signed weight width; ACC_BITS, default 24, signed score width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request one classification sweep.
REQ-007 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-008 SHALL have port rd_en, output, 1 bit: a read of cell_addr is issued this cycle.
REQ-009 SHALL have port cell_addr, output, $clog2(NUM_CELLS) bits: shared address to the voxel buffer and all per-class weight ROMs (address = bin*256 + cy*16 + cx).
REQ-010 SHALL have port voxel_count, input, COUNT_BITS bits, unsigned: voxel data, valid one cycle after rd_en.
REQ-011 SHALL have port weights, input, NUM_CLASSES*WEIGHT_BITS bits: signed weights, class k at bits [k*WEIGHT_BITS +: WEIGHT_BITS], valid one cycle after rd_en.
REQ-012 SHALL have port result_valid, output, 1 bit: one-cycle pulse when a result is ready.
REQ-013 SHALL have port result_class, output, $clog2(NUM_CLASSES) bits: winning class index.
REQ-014 SHALL have port result_score, output, ACC_BITS bits, signed: score of the winning class.

Function
REQ-015 FSM SHALL have states IDLE, SWEEP, DRAIN, ARGMAX, DONE.
REQ-016 IDLE with start=1: clear all accumulators, set the address counter to 0, go to SWEEP.
REQ-017 In SWEEP, rd_en=1 and cell_addr=counter; counter increments every cycle; after the cycle with counter=NUM_CELLS-1, go to DRAIN.
REQ-018 Read data SHALL be consumed exactly one cycle after its rd_en (delayed-valid register); DRAIN absorbs the final read; rd_en=0 in DRAIN.
REQ-019 On each valid data cycle, acc[k] += zero_extend(voxel_count) * signed weight[k], for all k in parallel.
REQ-020 Accumulation SHALL saturate at the signed ACC_BITS limits, with no wrap-around.
REQ-021 ARGMAX SHALL scan k = 0..NUM_CLASSES-1, one class per cycle, replacing the best only on strictly greater score; ties resolve to the lowest index.
REQ-022 DONE SHALL assert result_valid for exactly one cycle, then return to IDLE; result_class and result_score hold until the next DONE.
REQ-023 Latency: start sampled at cycle T gives result_valid at T+NUM_CELLS+NUM_CLASSES+2 (T+1286 at defaults).
REQ-024 start while busy SHALL be ignored; start in the DONE cycle is ignored.

Reset
REQ-025 rst SHALL force IDLE and clear counter, accumulators, delayed-valid and best registers.
REQ-026 On reset, outputs SHALL be busy=0, rd_en=0, cell_addr=0, result_valid=0, result_class=0, result_score=0.
REQ-027 rst mid-sweep SHALL abort with no result_valid; the next start SHALL run a clean sweep.

Structure
REQ-028 A shared package SHALL hold the class-index enum (UP=0, DOWN=1, LEFT=2, RIGHT=3), the FSM state typedef, and the default width constants.
REQ-029 A sub-module class_mac_lane (one MAC plus a saturating accumulator) SHALL be instantiated NUM_CLASSES times.

Verification
REQ-030 Counts all 1, weights per class constant k+1 -> scores 1280/2560/3840/5120; result_class=3, result_score=5120 at T+1286.
REQ-031 All counts 0 -> every score 0; result_class=0 (tie rule), result_score=0.
REQ-032 ACC_BITS=16, counts 255, class-0 weight 127, others -128 -> class 0 saturates to 32767, others to -32768; result_class=0.
REQ-033 Assert rst while cell_addr=500 -> busy=0 next cycle and no result_valid; a following start yields a correct single result.
REQ-034 Pulse start again at cycle T+100 -> ignored; exactly one result_valid, at T+1286.
REQ-035 Real ROM patterns, count 10 only at cell 0 (cx=0, cy=0) -> LEFT=960, UP=960; result_class=0 (UP) by tie rule.

Source files
------------

// File: rtl/class_score_engine_pkg.sv
// class_score_engine_pkg: shared class indices, FSM state encoding and default widths
// for the gesture class scoring engine.
package class_score_engine_pkg;
   typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} class_e;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_SWEEP  = 3'd1;
   localparam state_t S_DRAIN  = 3'd2;
   localparam state_t S_ARGMAX = 3'd3;
   localparam state_t S_DONE   = 3'd4;
   localparam int DEF_NUM_CLASSES = 4;
   localparam int DEF_NUM_CELLS   = 1280;
   localparam int DEF_COUNT_BITS  = 8;
   localparam int DEF_WEIGHT_BITS = 8;
   localparam int DEF_ACC_BITS    = 24;
endpackage

// File: rtl/class_mac_lane.sv
// class_mac_lane: one multiply-accumulate lane with a saturating signed accumulator.
// Ports: clk, rst (sync, active high), clr (zero the accumulator), en (accumulate this cycle),
//        count (unsigned voxel count), weight (signed), acc (signed running score).
module class_mac_lane
   import class_score_engine_pkg::*;
#(
   parameter int COUNT_BITS  = DEF_COUNT_BITS,
   parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
   parameter int ACC_BITS    = DEF_ACC_BITS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          en,
   input  logic [COUNT_BITS-1:0]         count,
   input  logic signed [WEIGHT_BITS-1:0] weight,
   output logic signed [ACC_BITS-1:0]    acc
);
   localparam int PROD_BITS = COUNT_BITS + 1 + WEIGHT_BITS;
   // one guard bit above the wider operand so the sum never overflows before clamping
   localparam int SUM_BITS  = (ACC_BITS > PROD_BITS ? ACC_BITS : PROD_BITS) + 1;
   localparam logic signed [SUM_BITS-1:0] MAXV = {{(SUM_BITS-ACC_BITS+1){1'b0}}, {(ACC_BITS-1){1'b1}}};
   localparam logic signed [SUM_BITS-1:0] MINV = {{(SUM_BITS-ACC_BITS+1){1'b1}}, {(ACC_BITS-1){1'b0}}};
   logic signed [PROD_BITS-1:0] prod;
   logic signed [SUM_BITS-1:0]  sum;
   logic signed [ACC_BITS-1:0]  sat;
   always_comb begin
      // count is zero-extended so it is always treated as non-negative
      prod = PROD_BITS'($signed({1'b0, count})) * PROD_BITS'(weight);
      sum  = SUM_BITS'(acc) + SUM_BITS'(prod);
      sat  = sum > MAXV ? MAXV[ACC_BITS-1:0] : sum < MINV ? MINV[ACC_BITS-1:0] : sum[ACC_BITS-1:0];
   end
   always_ff @(posedge clk)
      if (rst || clr) acc <= '0;
      else if (en) acc <= sat;
endmodule

// File: rtl/class_score_engine.sv
// class_score_engine: sweeps all voxel cells, scores every gesture class in parallel and
// reports the arg-max class.
// Ports: clk, rst (sync, active high), start (begin a sweep), busy (not idle),
//        rd_en/cell_addr (shared read to voxel buffer and weight ROMs),
//        voxel_count/weights (read data, one cycle after rd_en),
//        result_valid (one-cycle pulse), result_class/result_score (held winner).
module class_score_engine
   import class_score_engine_pkg::*;
#(
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int NUM_CELLS   = DEF_NUM_CELLS,
   parameter int COUNT_BITS  = DEF_COUNT_BITS,
   parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
   parameter int ACC_BITS    = DEF_ACC_BITS
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   output logic                               busy,
   output logic                               rd_en,
   output logic [$clog2(NUM_CELLS)-1:0]       cell_addr,
   input  logic [COUNT_BITS-1:0]              voxel_count,
   input  logic [NUM_CLASSES*WEIGHT_BITS-1:0] weights,
   output logic                               result_valid,
   output logic [$clog2(NUM_CLASSES)-1:0]     result_class,
   output logic signed [ACC_BITS-1:0]         result_score
);
   localparam int AW = $clog2(NUM_CELLS);
   localparam int CW = $clog2(NUM_CLASSES);
   localparam logic [AW-1:0] LAST_CELL  = AW'(NUM_CELLS - 1);
   localparam logic [CW-1:0] LAST_CLASS = CW'(NUM_CLASSES - 1);
   state_t                     state;
   logic [AW-1:0]              cnt;
   logic                       dv;
   logic [CW-1:0]              idx;
   logic [CW-1:0]              b_cls;
   logic signed [ACC_BITS-1:0] b_sc;
   logic signed [ACC_BITS-1:0] acc [NUM_CLASSES];
   logic                       take;
   logic [CW-1:0]              n_cls;
   logic signed [ACC_BITS-1:0] n_sc;
   assign busy         = state != S_IDLE;
   assign rd_en        = state == S_SWEEP;
   assign cell_addr    = cnt;
   assign result_valid = state == S_DONE;
   genvar k;
   generate
      for (k = 0; k < NUM_CLASSES; k++) begin : g_lane
         class_mac_lane #(
            .COUNT_BITS (COUNT_BITS),
            .WEIGHT_BITS(WEIGHT_BITS),
            .ACC_BITS   (ACC_BITS)
         ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (state == S_IDLE && start),
            .en    (dv),
            .count (voxel_count),
            .weight(weights[k*WEIGHT_BITS +: WEIGHT_BITS]),
            .acc   (acc[k])
         );
      end
   endgenerate
   // class 0 seeds the scan so negative scores still compete; later classes win only when strictly greater
   always_comb begin
      take  = idx == '0 || acc[idx] > b_sc;
      n_cls = take ? idx : b_cls;
      n_sc  = take ? acc[idx] : b_sc;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         dv           <= 1'b0;
         idx          <= '0;
         b_cls        <= '0;
         b_sc         <= '0;
         result_class <= '0;
         result_score <= '0;
      end else begin
         dv <= state == S_SWEEP;
         case (state)
            S_IDLE: if (start) begin
               state <= S_SWEEP;
               cnt   <= '0;
            end
            S_SWEEP: begin
               cnt <= cnt == LAST_CELL ? '0 : cnt + AW'(1);
               if (cnt == LAST_CELL) state <= S_DRAIN;
            end
            S_DRAIN: begin
               state <= S_ARGMAX;
               idx   <= '0;
            end
            S_ARGMAX: begin
               b_cls <= n_cls;
               b_sc  <= n_sc;
               idx   <= idx + CW'(1);
               if (idx == LAST_CLASS) begin
                  state        <= S_DONE;
                  result_class <= n_cls;
                  result_score <= n_sc;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
